// File: rtl/data_mem_interface_pkg.sv
// Shared types for the data-memory interface: write-buffer entry layout and FSM states.
// Imported by the FIFO, the top level and anything that needs the entry format.
package dmem_pkg;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ_DONE
    } dmem_state_t;

    function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

    function automatic wb_entry_t make_entry(input logic [31:0] byte_addr,
                                             input logic [31:0] data,
                                             input logic [3:0]  be);
        wb_entry_t e;
        e.addr = word_addr(byte_addr);
        e.data = data;
        e.be   = be;
        return e;
    endfunction

endpackage

// File: rtl/data_mem_interface_if.sv
// Core-side request bus and memory-side Req/Ready bus of the data-memory interface.
// "master" is the side that issues requests on each bus.
interface dmem_core_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        ReadEnable;
    logic        WriteEnable;
    logic [3:0]  ByteEnable;
    logic [31:0] ReadData;
    logic        Ack;

    modport master (
        output Address, WriteData, ReadEnable, WriteEnable, ByteEnable,
        input  ReadData, Ack
    );

    modport slave (
        input  Address, WriteData, ReadEnable, WriteEnable, ByteEnable,
        output ReadData, Ack
    );
endinterface

interface dmem_mem_if;
    logic [29:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBE;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemRData;
    logic        MemReady;

    modport master (
        output MemAddr, MemWData, MemBE, MemReq, MemWe,
        input  MemRData, MemReady
    );

    modport slave (
        input  MemAddr, MemWData, MemBE, MemReq, MemWe,
        output MemRData, MemReady
    );
endinterface

// File: rtl/data_mem_interface_write_buffer_fifo.sv
// Circular write buffer for posted stores. Exposes the head and the entry behind it so
// the drain logic can load the next write into its output registers on the same pop.
module write_buffer_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                dout,
    output wb_entry_t                dout_next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        storage [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full      = (count == CW'(DEPTH));
        empty     = (count == '0);
        push_ok   = push && !full;
        pop_ok    = pop && !empty;
        dout      = storage[rd_ptr];
        dout_next = storage[rd_ptr + PW'(1)];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            storage[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_interface.sv
// Bridges the core's level-held load/store request to a Req/Ready memory port, posting
// stores through a write buffer and ordering loads behind every buffered store.
module data_mem_interface
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    dmem_core_if.slave core,
    dmem_mem_if.master mem
);

    localparam int CW = $clog2(DEPTH) + 1;

    dmem_state_t  state;
    dmem_state_t  state_next;

    wb_entry_t    wb_din;
    wb_entry_t    wb_dout;
    wb_entry_t    wb_dout_next;
    logic [CW-1:0] wb_count;
    logic         wb_full;
    logic         wb_empty;
    logic         wb_push;
    logic         wb_pop;

    logic [29:0]  mem_addr_q,  mem_addr_d;
    logic [31:0]  mem_wdata_q, mem_wdata_d;
    logic [3:0]   mem_be_q,    mem_be_d;
    logic         mem_req_q,   mem_req_d;
    logic         mem_we_q,    mem_we_d;
    logic [31:0]  read_data_q, read_data_d;

    logic         write_ack;
    logic         read_accept;
    logic         more_after_pop;
    wb_entry_t    next_head;

    write_buffer_fifo #(
        .DEPTH(DEPTH)
    ) u_wb (
        .clk       (CLK),
        .rst       (RST),
        .push      (wb_push),
        .pop       (wb_pop),
        .din       (wb_din),
        .dout      (wb_dout),
        .dout_next (wb_dout_next),
        .count     (wb_count),
        .full      (wb_full),
        .empty     (wb_empty)
    );

    // A zero lane mask completes immediately without occupying a buffer slot.
    always_comb begin
        wb_din      = make_entry(core.Address, core.WriteData, core.ByteEnable);
        write_ack   = core.WriteEnable && ((core.ByteEnable == 4'b0000) || !wb_full);
        wb_push     = core.WriteEnable && (core.ByteEnable != 4'b0000) && !wb_full;
        read_accept = core.ReadEnable && !core.WriteEnable && (state == IDLE) && wb_empty;
        wb_pop      = (state == WRITE) && mem_req_q && mem.MemReady;

        more_after_pop = (wb_count > CW'(1)) || wb_push;
        next_head      = (wb_count > CW'(1)) ? wb_dout_next : wb_din;

        core.Ack      = !RST && (write_ack || (state == READ_DONE));
        core.ReadData = read_data_q;

        mem.MemAddr  = mem_addr_q;
        mem.MemWData = mem_wdata_q;
        mem.MemBE    = mem_be_q;
        mem.MemReq   = mem_req_q;
        mem.MemWe    = mem_we_q;
    end

    // Memory-side outputs are computed here and registered, so they only move when a
    // state is entered or when a drained write is replaced by the next buffered one.
    always_comb begin
        state_next  = state;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        read_data_d = read_data_q;

        case (state)
            IDLE: begin
                if (read_accept) begin
                    state_next = READ_WAIT;
                    mem_addr_d = word_addr(core.Address);
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                end else if (!wb_empty || wb_push) begin
                    state_next  = WRITE;
                    mem_addr_d  = wb_empty ? wb_din.addr : wb_dout.addr;
                    mem_wdata_d = wb_empty ? wb_din.data : wb_dout.data;
                    mem_be_d    = wb_empty ? wb_din.be   : wb_dout.be;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                end
            end

            WRITE: begin
                if (wb_pop) begin
                    if (more_after_pop && !core.ReadEnable) begin
                        mem_addr_d  = next_head.addr;
                        mem_wdata_d = next_head.data;
                        mem_be_d    = next_head.be;
                    end else begin
                        state_next = IDLE;
                        mem_req_d  = 1'b0;
                        mem_we_d   = 1'b0;
                    end
                end
            end

            READ_WAIT: begin
                if (mem.MemReady) begin
                    state_next  = READ_DONE;
                    read_data_d = mem.MemRData;
                    mem_req_d   = 1'b0;
                end
            end

            READ_DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            read_data_q <= '0;
        end else begin
            state       <= state_next;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            read_data_q <= read_data_d;
        end
    end

endmodule

// File: doc/data_mem_interface.md
# data_mem_interface

Sits between the core's data-memory port and a multi-cycle data SRAM/bus. Converts the core's level-held read/write request into a Req/Ready memory handshake and posts writes through a small write buffer, so stores complete without waiting on memory. Reads are ordered behind all buffered writes. Ack is the stall release that the core's memory controller consumes on its DataMem_Ack input.

## Interface
- DEPTH, 4: write-buffer entries (power of two, ≥2)
- CLK  input  1  clock
- RST  input  1  synchronous reset, active-high
- Address  input  32  byte address from the core; [1:0] ignored, word address is Address[31:2]
- WriteData  input  32  store data from the core
- ReadEnable  input  1  load request, held until Ack
- WriteEnable  input  1  store request, held until Ack
- ByteEnable  input  4  store lane mask, bit i selects byte [8i+7:8i]
- ReadData  output  32  load data, valid in the Ack cycle of a read
- Ack  output  1  request complete; core drops or changes the request next cycle
- MemAddr  output  30  word address to memory
- MemWData  output  32  write data to memory
- MemBE  output  4  write lane mask to memory
- MemReq  output  1  memory transaction request
- MemWe  output  1  1 = write, 0 = read (valid with MemReq)
- MemRData  input  32  read data, valid when MemReady and read
- MemReady  input  1  memory accepts/completes the current transaction this cycle

## Operation
- FSM states: IDLE, WRITE (draining buffer head), READ_WAIT (waiting on read), READ_DONE (one-cycle Ack).
- Write: if WriteEnable and count < DEPTH, push {Address[31:2], WriteData, ByteEnable}; Ack = 1 combinationally that cycle. If full, Ack = 0 until a slot frees. ByteEnable = 4'b0000: Ack = 1 and nothing is queued.
- Drain: in IDLE with count > 0 and no read accepted, enter WRITE. MemReq = 1, MemWe = 1, with head fields on MemAddr/MemWData/MemBE held stable. On MemReady the head is popped. Go to IDLE, or stay in WRITE if count after pop > 0 and no read is pending.
- Read: accepted only in IDLE with count == 0. Latch Address[31:2] and enter READ_WAIT. MemReq = 1, MemWe = 0. On MemReady, register MemRData into ReadData and enter READ_DONE. In READ_DONE, Ack = 1, then return to IDLE.
- Read while buffer non-empty: the buffer drains fully first. No forwarding. Writes arriving during the drain are not pushed because the core is stalled on its read.
- ReadEnable and WriteEnable both high is illegal; WriteEnable takes priority.
- Push and pop in the same cycle are allowed; count is unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

## Timing
- Reset values: Ack 0, ReadData 0, MemReq 0, MemWe 0, MemAddr 0, MemWData 0, MemBE 0, count 0, state IDLE.
- Memory outputs are registered. They change only on entering a state or on a MemReady pop.
- Store latency to Ack: 0 cycles (same cycle) when not full.
- Load latency: accepted in cycle t, MemReq from t+1, MemReady at t+k (k ≥ 1), Ack at t+k+1. Minimum is 2 cycles with MemReady tied high.
- Back-to-back drain with MemReady held high: one write per cycle.
- MemReady while MemReq = 0 is ignored.
- RST mid-transaction: buffer flushed, pending writes discarded, MemReq = 0 the cycle after RST is sampled.

## Structure
- Package dmem_pkg holds:
  - typedef wb_entry_t {logic [29:0] addr; logic [31:0] data; logic [3:0] be;}
  - enum dmem_state_t {IDLE, WRITE, READ_WAIT, READ_DONE}
- One sub-module, write_buffer_fifo, parameterised by DEPTH and storing wb_entry_t.
  - Ports: push, pop, din, dout, count, full, empty.
- The FSM and read path live in data_mem_interface.

## Test plan
- Single store with MemReady tied high:
  - Stimulus: Address 0x100, WriteData 0xDEADBEEF, ByteEnable 4'b1111.
  - Response: Ack the same cycle. Next cycle MemReq = 1, MemWe = 1, MemAddr 0x40. Pop, then IDLE.
- Load with 3-cycle memory:
  - Stimulus: empty buffer, read Address 0x200, MemReady high 3 cycles after MemReq rises, MemRData 0x12345678.
  - Response: Ack with ReadData 0x12345678 exactly one cycle after MemReady.
- Buffer full:
  - Stimulus: MemReady held low, 5 consecutive stores with DEPTH = 4.
  - Response: stores 1–4 Ack'd. Store 5 Ack = 0 until the first MemReady pop, then Ack'd.
- Ordering:
  - Stimulus: store 0xAAAA0000 to 0x300 (BE 4'b1100), then load 0x300.
  - Response: the memory write is observed before the read MemReq. The load Ack follows the drain.
- Edge cases:
  - ByteEnable = 4'b0000: Ack'd, no MemReq issued.
  - Wrap test: 10 stores with random MemReady stalls. All 10 appear on the memory port in order, with correct addresses and lane masks.
- Reset mid-read:
  - Stimulus: assert RST while in READ_WAIT.
  - Response: next cycle MemReq = 0, Ack = 0, count = 0, and no stale Ack after RST deasserts.
